// File: rtl/dmem_responder_if.sv
// Load/store channel between the core's memory stage and dmem_responder.
// master: processor side (drives requests, accepts responses).
// slave : responder side (accepts requests, drives responses).
//   req_valid/req_ready        request handshake
//   req_we                     1 = store, 0 = load
//   req_addr[31:0]             byte address
//   req_size[1:0]              00 byte, 01 half, 10/11 word
//   req_unsigned               zero-extend loads when set
//   req_wdata[31:0]            right-justified store data
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata[31:0]            load result, 0 for stores and errors
//   rsp_err                    access error
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32 load/store path.
// Accepts one request at a time, waits LATENCY cycles, then accesses a
// word-organised array and returns the result on the response channel.
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-low reset
//   bus  dmem_responder_if.slave (request and response channels)
// Parameters:
//   DEPTH    number of 32-bit words (word index = req_addr[31:2])
//   LATENCY  wait-state cycles, 0..15
// Build option:
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses
//                          respond with rsp_err and no write; otherwise
//                          the misaligned low address bits are ignored.
module dmem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic             CLK,
    input  logic             RST,
    dmem_responder_if.slave  bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_LAST = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    req_t          req_q;
    req_t          req_live_c;
    req_t          req_c;

    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;

    logic          accept_c;
    logic          rsp_take_c;
    logic          enter_resp_c;

    logic [AW-1:0] idx_c;
    logic [31:0]   word_c;
    logic          is_byte_c;
    logic          is_half_c;
    logic          oor_c;
    logic          err_c;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;
    logic [31:0]   rdata_c;
    logic [31:0]   wword_c;
    logic [3:0]    wmask_c;
    logic          wr_en_c;

    logic [31:0]   mem [DEPTH];

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign accept_c   = (state == ST_IDLE) & bus.req_valid & req_ready_q;
    // rsp_ready only counts once the response is actually visible
    assign rsp_take_c = rsp_valid_q & bus.rsp_ready;

    // Live request fields, used when the access edge is the acceptance edge
    always_comb begin
        req_live_c       = '0;
        req_live_c.we    = bus.req_we;
        req_live_c.addr  = bus.req_addr;
        req_live_c.size  = bus.req_size;
        req_live_c.uns   = bus.req_unsigned;
        req_live_c.wdata = bus.req_wdata;
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    cnt_nxt = '0;
                    if (LATENCY == 0) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_take_c) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign enter_resp_c = (state != ST_RESP) & (state_nxt == ST_RESP);

    // Access operands: with zero latency the access uses the live request
    assign req_c = (state == ST_IDLE) ? req_live_c : req_q;

    // Array access: range/alignment check, load lane extract, store lane merge
    always_comb begin
        is_byte_c = (req_c.size == SZ_BYTE);
        is_half_c = (req_c.size == SZ_HALF);
        idx_c     = req_c.addr[AW+1:2];
        oor_c     = (req_c.addr[31:2] >= 30'(DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
        err_c     = oor_c
                  | (is_half_c & req_c.addr[0])
                  | (~is_byte_c & ~is_half_c & (req_c.addr[1:0] != 2'b00));
`else
        err_c     = oor_c;
`endif
        word_c    = mem[idx_c];
        byte_c    = word_c[7:0];
        half_c    = req_c.addr[1] ? word_c[31:16] : word_c[15:0];
        rdata_c   = '0;
        wword_c   = req_c.wdata;
        wmask_c   = 4'b1111;

        case (req_c.addr[1:0])
            2'd0:    byte_c = word_c[7:0];
            2'd1:    byte_c = word_c[15:8];
            2'd2:    byte_c = word_c[23:16];
            default: byte_c = word_c[31:24];
        endcase

        if (is_byte_c) begin
            rdata_c = req_c.uns ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
            wword_c = {4{req_c.wdata[7:0]}};
            wmask_c = 4'b0001 << req_c.addr[1:0];
        end else if (is_half_c) begin
            rdata_c = req_c.uns ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
            wword_c = {2{req_c.wdata[15:0]}};
            wmask_c = req_c.addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            rdata_c = word_c;
        end

        if (req_c.we | err_c) begin
            rdata_c = '0;
        end

        wr_en_c = enter_resp_c & req_c.we & ~err_c;
    end

    // Storage array; contents are intentionally not reset
    always_ff @(posedge CLK) begin
        if (wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_c[b]) begin
                    mem[idx_c][8*b +: 8] <= wword_c[8*b +: 8];
                end
            end
        end
    end

    // Request capture and registered handshake/response outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            req_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                req_q <= req_live_c;
            end
            req_ready_q <= (state_nxt == ST_IDLE);
            rsp_valid_q <= (state_nxt == ST_RESP);
            if (enter_resp_c) begin
                rsp_rdata_q <= rdata_c;
                rsp_err_q   <= err_c;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios from the block
// description plus randomized traffic against a byte-addressed model.
module tb_dmem_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus.slave)
    );

    int unsigned pass_cnt  = 0;
    int unsigned check_cnt = 0;

    logic [7:0] ref_mem [0:DEPTH*4-1];

    // Behavioural model: byte-addressed memory, little-endian lanes
    function automatic void ref_op(input bit we, input logic [31:0] addr, input logic [1:0] size,
                                   input bit uns, input logic [31:0] wdata,
                                   output logic [31:0] rd, output bit err);
        int unsigned n;
        int unsigned base;
        n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        err = ((addr >> 2) >= DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((addr % n) != 0) err = 1'b1;
`endif
        base = addr - (addr % n);
        rd   = 32'h0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < int'(n); i++) ref_mem[base + i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(n)) rd[8*i +: 8] = ref_mem[base + i];
                else             rd[8*i +: 8] = (!uns && rd[8*n-1]) ? 8'hFF : 8'h00;
            end
        end
    endfunction

    // Drives one transaction; starts and ends 1 time unit after a rising edge
    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [1:0] size,
                           input bit uns, input logic [31:0] wdata, input int stall,
                           input bit early_ready,
                           output logic [31:0] rd, output logic err, output int lat,
                           output bit ready_low, output bit stable, output bit idle_after,
                           output bit timeout);
        int n;
        timeout = 0; ready_low = 1; stable = 1; idle_after = 0; lat = 0;
        rd = '0; err = 1'b0;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        bus.rsp_ready    = early_ready;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.req_ready) begin
            timeout = 1; bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the responder must ignore them
        bus.req_valid    = 1'b0;
        bus.req_we       = ~we;
        bus.req_addr     = $urandom;
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = ~uns;
        bus.req_wdata    = $urandom;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            if (bus.req_ready) ready_low = 0;
            @(posedge clk); #1; lat++;
        end
        if (!bus.rsp_valid) begin
            timeout = 1; bus.rsp_ready = 1'b0;
            return;
        end
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        if (bus.req_ready) ready_low = 0;
        if (!early_ready) begin
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                if (!bus.rsp_valid || bus.rsp_rdata !== rd || bus.rsp_err !== err) stable = 0;
                if (bus.req_ready) ready_low = 0;
            end
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        idle_after = !bus.rsp_valid && bus.req_ready;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = '0;
        bus.req_size     = '0;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cnt++;
        if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready got %b want 0", bus.req_ready);
        else pass_cnt++;
        check_cnt++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid);
        else pass_cnt++;
        check_cnt++;
        if ({bus.rsp_err, bus.rsp_rdata} !== 33'h0)
            $display("FAIL reset_rsp_data got err=%b rdata=%h want 0/0", bus.rsp_err, bus.rsp_rdata);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        check_cnt++;
        if (bus.req_ready !== 1'b0) $display("FAIL release_before_edge got %b want 0", bus.req_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++;
        if (bus.req_ready !== 1'b1) $display("FAIL release_after_edge got %b want 1", bus.req_ready);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        logic [31:0] rd, erd, d;
        logic err; bit eerr;
        int lat; bit rl, st, ia, to;
        for (int w = 0; w < 64; w++) begin
            d = $urandom;
            ref_op(1'b1, 32'(w*4), 2'b10, 1'b0, d, erd, eerr);
            run_txn(1'b1, 32'(w*4), 2'b10, 1'b0, d, 0, 1'b1, rd, err, lat, rl, st, ia, to);
            check_cnt++;
            if (to || err !== 1'b0 || rd !== 32'h0 || !ia)
                $display("FAIL fill_store w=%0d got err=%b rd=%h idle=%b to=%b want 0/0/1/0", w, err, rd, ia, to);
            else pass_cnt++;
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, erd;
        logic err; bit eerr;
        int lat; bit rl, st, ia, to;
        ref_op(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, erd, eerr);
        run_txn(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, 1'b0, rd, err, lat, rl, st, ia, to);
        check_cnt++;
        if (to || lat != int'(LATENCY) + 1)
            $display("FAIL store_latency got %0d (to=%b) want %0d", lat, to, LATENCY + 1);
        else pass_cnt++;
        check_cnt++;
        if (err !== 1'b0 || rd !== 32'h0 || !rl || !ia)
            $display("FAIL store_word got err=%b rd=%h ready_low=%b idle=%b want 0/0/1/1", err, rd, rl, ia);
        else pass_cnt++;
        run_txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, 1'b0, rd, err, lat, rl, st, ia, to);
        check_cnt++;
        if (to || rd !== 32'hDEADBEEF || err !== 1'b0)
            $display("FAIL load_word got %h err=%b want deadbeef/0", rd, err);
        else pass_cnt++;
        run_txn(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0, 1'b0, rd, err, lat, rl, st, ia, to);
        check_cnt++;
        if (to || rd !== 32'hFFFFFFDE) $display("FAIL load_byte_signed got %h want ffffffde", rd);
        else pass_cnt++;
        run_txn(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, 1'b0, rd, err, lat, rl, st, ia, to);
        check_cnt++;
        if (to || rd !== 32'h000000DE) $display("FAIL load_byte_unsigned got %h want 000000de", rd);
        else pass_cnt++;
        run_txn(1'b0, 32'h10, 2'b01, 1'b0, 32'h0, 0, 1'b0, rd, err, lat, rl, st, ia, to);
        check_cnt++;
        if (to || rd !== 32'hFFFFBEEF) $display("FAIL load_half_signed got %h want ffffbeef", rd);
        else pass_cnt++;
        ref_op(1'b1, 32'h11, 2'b00, 1'b0, 32'h55, erd, eerr);
        run_txn(1'b1, 32'h11, 2'b00, 1'b0, 32'h55, 0, 1'b0, rd, err, lat, rl, st, ia, to);
        run_txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, 1'b0, rd, err, lat, rl, st, ia, to);
        check_cnt++;
        if (to || rd !== 32'hDEAD55EF) $display("FAIL partial_store got %h want dead55ef", rd);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic err;
        int lat; bit rl, st, ia, to;
        run_txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 5, 1'b0, rd, err, lat, rl, st, ia, to);
        check_cnt++;
        if (to || rd !== 32'hDEAD55EF || !st)
            $display("FAIL backpressure_data got %h stable=%b want dead55ef/1", rd, st);
        else pass_cnt++;
        check_cnt++;
        if (!rl || !ia) $display("FAIL backpressure_hs got ready_low=%b idle_after=%b want 1/1", rl, ia);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic err;
        int lat; bit rl, st, ia, to;
        run_txn(1'b0, 32'(DEPTH*4), 2'b10, 1'b0, 32'h0, 0, 1'b0, rd, err, lat, rl, st, ia, to);
        check_cnt++;
        if (to || err !== 1'b1 || rd !== 32'h0)
            $display("FAIL oor_load got err=%b rd=%h want 1/0", err, rd);
        else pass_cnt++;
        check_cnt++;
        if (lat != int'(LATENCY) + 1) $display("FAIL oor_latency got %0d want %0d", lat, LATENCY + 1);
        else pass_cnt++;
        run_txn(1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 0, 1'b0, rd, err, lat, rl, st, ia, to);
        check_cnt++;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (to || err !== 1'b1 || rd !== 32'h0)
            $display("FAIL misaligned_word got err=%b rd=%h want 1/0", err, rd);
        else pass_cnt++;
`else
        if (to || err !== 1'b0 || rd !== 32'hDEAD55EF)
            $display("FAIL misaligned_word got err=%b rd=%h want 0/dead55ef", err, rd);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] old, rd;
        logic err;
        int lat, n; bit rl, st, ia, to, seen;
        old = {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]};
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_size  = 2'b10;
        bus.req_wdata = ~old;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0)
            $display("FAIL midwait_reset_outputs got valid=%b ready=%b want 0/0", bus.rsp_valid, bus.req_ready);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1;
        end
        check_cnt++;
        if (seen) $display("FAIL midwait_no_response got rsp_valid=1 want 0");
        else pass_cnt++;
        run_txn(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, 1'b0, rd, err, lat, rl, st, ia, to);
        check_cnt++;
        if (to || rd !== old || err !== 1'b0)
            $display("FAIL midwait_store_dropped got %h err=%b want %h/0", rd, err, old);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, d;
        logic err; bit eerr, we, uns, early;
        logic [1:0] size;
        int lat, stall; bit rl, st, ia, to;
        for (int t = 0; t < 40; t++) begin
            we    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            early = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            stall = $urandom_range(0, 3);
            d     = $urandom;
            if ($urandom_range(0, 9) == 0) addr = 32'(DEPTH*4) + 32'($urandom_range(0, 4095));
            else                           addr = 32'($urandom_range(0, 255));
            ref_op(we, addr, size, uns, d, erd, eerr);
            run_txn(we, addr, size, uns, d, stall, early, rd, err, lat, rl, st, ia, to);
            check_cnt++;
            if (to || rd !== erd || err !== eerr)
                $display("FAIL rand_result t=%0d we=%b a=%h sz=%0d u=%b got %h/%b want %h/%b",
                         t, we, addr, size, uns, rd, err, erd, eerr);
            else pass_cnt++;
            check_cnt++;
            if (lat != int'(LATENCY) + 1 || !rl || !st || !ia)
                $display("FAIL rand_timing t=%0d got lat=%0d rl=%b st=%b idle=%b want %0d/1/1/1",
                         t, lat, rl, st, ia, LATENCY + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc, n_acc;
        int acc[2];
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.rsp_ready    = 1'b1;
        n_acc = 0; cyc = 0;
        acc[0] = 0; acc[1] = 0;
        while (n_acc < 2 && cyc < 30) begin
            if (bus.req_ready) begin
                acc[n_acc] = cyc;
                n_acc++;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.req_valid = 1'b0;
        cyc = 0;
        while (!bus.req_ready && cyc < 30) begin
            @(posedge clk); #1; cyc++;
        end
        bus.rsp_ready = 1'b0;
        check_cnt++;
        if (n_acc != 2 || acc[1] - acc[0] != int'(LATENCY) + 2)
            $display("FAIL throughput got accepts=%0d spacing=%0d want 2/%0d",
                     n_acc, acc[1] - acc[0], LATENCY + 2);
        else pass_cnt++;
        check_cnt++;
        if (!bus.req_ready || bus.rsp_valid)
            $display("FAIL back_to_back_drain got ready=%b valid=%b want 1/0", bus.req_ready, bus.rsp_valid);
        else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_backpressure();
        test_errors();
        test_reset_mid_wait();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32 core's load/store path. Accepts one load or store request at a time over a valid/ready channel and services it from a word-organised internal array after a programmable number of wait states. Returns the result over a second valid/ready channel. Sits between the processor's memory stage and the data-memory model; benches drive it from the processor side.

## Interface
- `DEPTH`, 1024: number of 32-bit words; word index = `req_addr[31:2]`.
- `LATENCY`, 2: wait-state cycles between acceptance and response, 0..15.
- `CLK` in 1: rising-edge clock.
- `RST` in 1: reset, **asynchronous, active-low**. All state clears while low.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 00 byte, 01 half, 10 word. 11 is treated as word.
- `req_unsigned` in 1: loads zero-extend when 1, sign-extend when 0.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: out-of-range access, or misaligned access when `DMEM_MISALIGN_TRAP_EN` is defined.

## Operation
- FSM states:
  - IDLE: `req_ready=1`.
  - WAIT: count `LATENCY` cycles.
  - RESP: `rsp_valid=1`.
- Transitions:
  - IDLE→WAIT on `req_valid & req_ready`, when `LATENCY>0`.
  - IDLE→RESP on acceptance, when `LATENCY==0`.
  - WAIT→RESP when the counter reaches `LATENCY-1`.
  - RESP→IDLE on `rsp_ready`.
- Request capture: `we`, `addr`, `size`, `unsigned` and `wdata` are registered at acceptance. Later input changes are ignored.
- Array access happens on the edge entering RESP; `rsp_rdata` and `rsp_err` are registered on that edge.
- Range check: word index ≥ `DEPTH` sets `rsp_err=1`, suppresses the write and forces rdata to 0.
- Loads:
  - Byte lane selected by `addr[1:0]`; half lane by `addr[1]`.
  - Result extended to 32 bits per `req_unsigned`.
- Stores:
  - Byte writes lane `addr[1:0]` with `wdata[7:0]`.
  - Half writes `addr[1]` lane with `wdata[15:0]`.
  - Word writes all four lanes.
  - Other lanes are unchanged.
- Array contents are not reset. Reads of never-written words return X in simulation.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `req_ready=0` while `RST` is low, 1 from the first edge after release.
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
- Latency from the acceptance edge to `rsp_valid` high is `LATENCY+1` cycles.
- `req_ready` is low from the acceptance edge until the edge on which the response is taken. There is no back-to-back overlap.
- Throughput is one request per `LATENCY+2` cycles when `rsp_ready` is held high.
- Response hold: `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable while `rsp_valid & ~rsp_ready`, for an unbounded stall.
- `rsp_ready` asserted before `rsp_valid` has no effect.
- `RST` low mid-operation:
  - An in-flight request is dropped and the FSM returns to IDLE.
  - A store whose RESP edge has not occurred is not written.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Half with `addr[0]=1`, or word with `addr[1:0]!=0`, gives `rsp_err=1`, no write, rdata 0.
  - Latency is the same as a normal access.
- `DMEM_MISALIGN_TRAP_EN` not defined:
  - Misaligned low bits are forced to zero: half uses `addr[1]`, word ignores `addr[1:0]`.
  - No error is raised.
  - Out-of-range errors still apply in both modes.

## Test plan
- Reset then word store: `LATENCY=2`, store word `0x0000_0010`←`0xDEADBEEF` → `rsp_valid` 3 cycles after acceptance, `rsp_err=0`. Then word load from `0x10` → `0xDEADBEEF`.
- Byte/half extension: with `0xDEADBEEF` at `0x10`:
  - Load byte `0x13` signed → `0xFFFFFFDE`.
  - Load byte `0x13` unsigned → `0x000000DE`.
  - Load half `0x10` signed → `0xFFFFBEEF`.
- Partial store: store byte `0x11`←`0x55` → word load `0x10` returns `0xDEAD55EF`.
- Backpressure: hold `rsp_ready=0` for 5 cycles on a load → `rsp_valid` and data stable, `req_ready=0` throughout. Release → IDLE next cycle.
- Errors:
  - Load at `DEPTH*4` → `rsp_err=1`, rdata 0.
  - Word load `0x12` → `rsp_err=1` with the macro defined; without it, the word at `0x10` is returned.
- Reset mid-wait: assert `RST` low during WAIT of a store to `0x20` → `rsp_valid` never asserts, and a later load from `0x20` shows the old value.
